uart_rx_framer: RTL

Receive-side framing stage between a UART byte receiver and the Cypress slave-FIFO arbiter. It packs incoming UART bytes into big-endian 16-bit words in a single-message buffer. A message closes on an idle gap or a length limit. The block then presents the message to the arbiter through the same handshake the SPI and UART source channels use: GOT_FULL_MESSAGE, MSG_LEN, MSG_START, RD_REQ and FIFO_Q.

---
 rtl/uart_rx_framer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Packs UART bytes into big-endian 16-bit words held in a single-message
//   buffer (256x16 RAM). A message closes after an idle gap of GAP_CYCLES
//   clocks or when MAX_WORDS words have been written. The closed message is
//   handed to the slave-FIFO arbiter through the GOT_FULL_MESSAGE / MSG_LEN /
//   MSG_START / RD_REQ / FIFO_Q handshake.
//
//   Optional feature macro: UART_FRAMER_PARITY_EN
//     defined   : PARITY_OUT = OR of RX_PERR over the accepted bytes
//     undefined : RX_PERR ignored, PARITY_OUT tied to 0
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   RX_BYTE/RX_VALID    byte strobe from the UART receiver
//   RX_PERR             parity error for the strobed byte
//   MSG_START           arbiter pulse, starts the drain (READY only)
//   RD_REQ              arbiter word read strobe (DRAIN only)
//   GOT_FULL_MESSAGE    a closed message waits in the buffer
//   MSG_LEN             word count of the buffered message
//   FIFO_Q              registered RAM read data
//   PARITY_OUT          a byte of the message had a parity error
//   OVERFLOW            sticky: a byte arrived while a message was held
module uart_rx_framer #(
  parameter int GAP_CYCLES = 1000,
  parameter int MAX_WORDS  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_BYTE,
  input  logic        RX_VALID,
  input  logic        RX_PERR,
  input  logic        MSG_START,
  input  logic        RD_REQ,
  output logic        GOT_FULL_MESSAGE,
  output logic [7:0]  MSG_LEN,
  output logic [15:0] FIFO_Q,
  output logic        PARITY_OUT,
  output logic        OVERFLOW
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, READY, DRAIN} state_t;

  state_t        state, nxt;
  logic [15:0]   ram [256];
  logic [7:0]    wr_ptr, rd_ptr, hi_byte;
  logic          hi_pend;
  logic [GW-1:0] gap_cnt;

  logic          accept, wr_word, gap_exp, pad, len_hit, last_rd, we, close;
  logic [15:0]   wdata;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // next state and datapath strobes
  always_comb begin
    nxt     = state;
    accept  = RX_VALID && (state == IDLE || state == COLLECT);
    wr_word = accept && hi_pend;
    // a byte in the expiry cycle keeps the message open
    gap_exp = (state == COLLECT) && !RX_VALID &&
              (gap_cnt == GW'(GAP_CYCLES - 1));
    pad     = gap_exp && hi_pend;
    len_hit = wr_word && (wr_ptr == 8'(MAX_WORDS - 1));
    last_rd = (state == DRAIN) && RD_REQ && (rd_ptr == MSG_LEN - 8'd1);
    we      = wr_word || pad;
    wdata   = pad ? {hi_byte, 8'h00} : {hi_byte, RX_BYTE};
    close   = 1'b0;
    case (state)
      IDLE:    if (RX_VALID) nxt = COLLECT;
      COLLECT: if (len_hit || gap_exp) begin
                 nxt   = READY;
                 close = 1'b1;
               end
      READY:   if (MSG_START) nxt = DRAIN;
      DRAIN:   if (last_rd) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // message RAM, write port only
  always_ff @(posedge CLK) begin
    if (we) ram[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hi_byte  <= '0;
      hi_pend  <= 1'b0;
      gap_cnt  <= '0;
      MSG_LEN  <= '0;
      FIFO_Q   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (accept) begin
        gap_cnt <= '0;
        if (hi_pend) begin
          hi_pend <= 1'b0;
        end else begin
          hi_byte <= RX_BYTE;
          hi_pend <= 1'b1;
        end
      end else if (state == COLLECT) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (pad) hi_pend <= 1'b0;
      if (we)  wr_ptr  <= wr_ptr + 8'd1;
      // count includes the word written in the closing cycle
      if (close) MSG_LEN <= wr_ptr + {7'd0, we};
      if (RX_VALID && (state == READY || state == DRAIN)) OVERFLOW <= 1'b1;
      if (state == DRAIN && RD_REQ) begin
        FIFO_Q <= ram[rd_ptr];
        rd_ptr <= rd_ptr + 8'd1;
      end
      // entering IDLE: buffer becomes empty
      if (last_rd) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

`ifdef UART_FRAMER_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST || last_rd)         PARITY_OUT <= 1'b0;
    else if (accept && RX_PERR) PARITY_OUT <= 1'b1;
  end
`else
  logic unused_perr;
  assign unused_perr = RX_PERR;
  assign PARITY_OUT  = 1'b0;
`endif

  assign GOT_FULL_MESSAGE = (state == READY);

endmodule
